ccr_unit: RTL
=============

# ccr_unit

Condition-code register and flag consumer for the 16-bit RISC pipeline. It latches the 3-bit Z/N/C flags produced by the ALU under a per-instruction update mask, executes SETC/CLRC, resolves conditional jumps (JZ/JN/JC) and clears the tested flag on a taken jump. It also keeps a shadow stack of CCR values, pushed on interrupt entry and popped on RTI. It sits beside the execute stage, consumes the ALU `Ccr` output and feeds branch resolution in decode.

## Interface
- `DEPTH`, 4: shadow-stack entries; legal range 1..7.
- `LVL_W`, 3: width of `stack_lvl`; must satisfy DEPTH ≤ 2^LVL_W − 1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: freezes all state; forces `br_taken` to 0.
- `alu_valid` in 1: ALU result completes this cycle.
- `alu_ccr` in 3: ALU flags; [0]=Z, [1]=N, [2]=C.
- `alu_mask` in 3: flags the completing op is allowed to write; same bit order as `alu_ccr`.
- `setc` in 1: set C.
- `clrc` in 1: clear C.
- `br_valid` in 1: conditional jump in decode.
- `br_type` in 2: 01 JZ, 10 JN, 11 JC; 00 means none.
- `int_save` in 1: push CCR (interrupt entry).
- `rti_restore` in 1: pop CCR (RTI).
- `ccr` out 3: current flags (registered).
- `br_taken` out 1: combinational jump decision.
- `stack_lvl` out LVL_W: occupied stack entries.
- `ovf_err` out 1: sticky; a push was attempted while full.
- `unf_err` out 1: sticky; a pop was attempted while empty.

## Operation
- Reset values: `ccr` = 000, `stack_lvl` = 0, `ovf_err` = 0, `unf_err` = 0. Stack contents are don't-care.
- `br_taken` = `br_valid` & ~`stall` & (`br_type` ≠ 00) & `ccr`[`br_type` − 1]. It uses the registered CCR, never the value being computed this cycle.
- Next-CCR computation, in strict priority order:
  1. Start from `ccr`. If a taken jump occurs, clear the tested flag.
  2. If `alu_valid`, replace every bit where `alu_mask`=1 with the corresponding `alu_ccr` bit. An ALU write overrides a branch clear of the same flag.
  3. If `setc`, C=1. If `clrc`, C=0. When both are asserted, `clrc` wins. Both override the ALU C bit.
  4. If `rti_restore` is accepted, the popped value replaces the whole result of steps 1–3.
- `int_save`:
  - When the stack is not full, push the value from steps 1–3, then `stack_lvl`+1.
  - When the stack is full, drop the push, leave the stack unchanged and set `ovf_err`. CCR still updates normally.
- `rti_restore`:
  - When the stack is not empty, load the top entry into `ccr`, then `stack_lvl`−1.
  - When the stack is empty, apply steps 1–3 only and set `unf_err`.
- `int_save` and `rti_restore` in the same cycle: the save is performed and the restore is ignored (no error flagged).
- `stall`=1 holds `ccr`, the stack, `stack_lvl` and the error flags, and ignores all other inputs. `rst` overrides `stall`.
- The stack is LIFO and the pointer does not wrap. Both sticky errors clear only on `rst`.

## Timing
- Every registered output changes one cycle after the qualifying edge. The only combinational path is `br_taken`.
- ALU → `ccr` latency: 1 cycle. A jump in the cycle after the ALU op sees the new flags.
- A taken jump's flag clear is visible on `ccr` the next cycle. Back-to-back JZ with no intervening ALU write: the second jump is not taken.
- Push → pop → visible restored `ccr`: minimum 2 cycles, one per operation.
- A reset asserted mid-sequence, including while the stack is partially filled, discards the stack. `stack_lvl` reads 0 in the cycle after the reset edge.

## Configuration
- `CCR_STACK_EN`, defined: the shadow stack, `stack_lvl`, `ovf_err` and `unf_err` behave as above.
- `CCR_STACK_EN`, undefined: there is no stack storage.
  - `int_save` and `rti_restore` are ignored.
  - `stack_lvl`, `ovf_err` and `unf_err` are tied to 0.
  - Flag update and branch logic are unchanged.

## Test plan
- Reset, then ALU writes `alu_ccr`=101 with mask=111, then NOT-style ALU op `alu_ccr`=010 with mask=011 → `ccr` = 101, then 110 (C preserved).
- `ccr`=001, JZ issued (`br_valid`=1, `br_type`=01) → `br_taken`=1 and next `ccr`=000. A repeated JZ gives `br_taken`=0.
- `setc` and `clrc` together with an ALU write of C=1 (mask=100) → `ccr`[2]=0.
- DEPTH=4, five pushes with `ccr`=011 → `stack_lvl`=4 and `ovf_err`=1. Then four pops → `ccr`=011 and `stack_lvl`=0. A fifth pop → `unf_err`=1 and `ccr` unchanged.
- Push and pop in the same cycle with `stack_lvl`=1 → `stack_lvl`=2 and `unf_err`=0. `stall`=1 with every input active → all outputs frozen and `br_taken`=0.
- Build without `CCR_STACK_EN`: `int_save` pulses → `stack_lvl`=0 and `ovf_err`=0. Flag tests 1–3 still pass.

Source files
------------

// File: rtl/ccr_unit.sv
// Condition-code register (Z/N/C) with branch resolution and an optional CCR shadow stack.
// Define CCR_STACK_EN to build the interrupt shadow stack; otherwise stack outputs tie to 0.
module ccr_unit #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             alu_valid,
  input  logic [2:0]       alu_ccr,
  input  logic [2:0]       alu_mask,
  input  logic             setc,
  input  logic             clrc,
  input  logic             br_valid,
  input  logic [1:0]       br_type,
  input  logic             int_save,
  input  logic             rti_restore,
  output logic [2:0]       ccr,
  output logic             br_taken,
  output logic [LVL_W-1:0] stack_lvl,
  output logic             ovf_err,
  output logic             unf_err
);

  logic       tested;
  logic [2:0] ccr_next;
  logic [2:0] ccr_load;

  always_comb begin
    case (br_type)
      2'b01:   tested = ccr[0];
      2'b10:   tested = ccr[1];
      2'b11:   tested = ccr[2];
      default: tested = 1'b0;
    endcase
  end

  assign br_taken = br_valid & ~stall & tested;

  // Branch clear, then ALU write, then SETC/CLRC: later steps override earlier ones.
  always_comb begin
    ccr_next = ccr;
    if (br_taken) begin
      case (br_type)
        2'b01:   ccr_next[0] = 1'b0;
        2'b10:   ccr_next[1] = 1'b0;
        2'b11:   ccr_next[2] = 1'b0;
        default: ccr_next = ccr;
      endcase
    end
    if (alu_valid) ccr_next = (ccr_next & ~alu_mask) | (alu_ccr & alu_mask);
    if (setc) ccr_next[2] = 1'b1;
    if (clrc) ccr_next[2] = 1'b0;
  end

`ifdef CCR_STACK_EN
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]       stk [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             full, empty, push, pop;

  // Top entry sits at stack_lvl-1; the low bits alone suffice since stack_lvl <= DEPTH.
  assign wr_idx = stack_lvl[IDX_W-1:0];
  assign rd_idx = wr_idx - 1'b1;
  assign full   = (stack_lvl == LVL_W'(DEPTH));
  assign empty  = (stack_lvl == '0);
  assign push   = int_save & ~full;
  assign pop    = rti_restore & ~int_save & ~empty;

  always_ff @(posedge clk) begin
    if (!stall && push) stk[wr_idx] <= ccr_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stack_lvl <= '0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
    end else if (!stall) begin
      if (push)     stack_lvl <= stack_lvl + 1'b1;
      else if (pop) stack_lvl <= stack_lvl - 1'b1;
      if (int_save && full) ovf_err <= 1'b1;
      if (rti_restore && !int_save && empty) unf_err <= 1'b1;
    end
  end

  assign ccr_load = pop ? stk[rd_idx] : ccr_next;
`else
  logic unused_stack_in;
  assign unused_stack_in = &{1'b0, int_save, rti_restore};
  assign ccr_load  = ccr_next;
  assign stack_lvl = '0;
  assign ovf_err   = 1'b0;
  assign unf_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)         ccr <= 3'b000;
    else if (!stall) ccr <= ccr_load;
  end

endmodule
